// File: rtl/reservation_station_pkg.sv
// rtl/reservation_station_pkg.sv - shared types, widths and op encodings for the reservation station
package reservation_station_pkg;

    localparam int TAG_W  = 3;
    localparam int DATA_W = 16;

    localparam logic [TAG_W-1:0] TAG_READY = 3'd0;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_WAITING,
        ST_READY,
        ST_EXECUTING
    } entry_state_t;

    // A broadcast satisfies an operand only when the operand is actually waiting on a producer.
    function automatic logic tag_hit(input logic valid, input logic [TAG_W-1:0] bus_tag,
                                     input logic [TAG_W-1:0] q);
        return valid && (q != TAG_READY) && (bus_tag == q);
    endfunction

endpackage

// File: rtl/reservation_station_entry.sv
// rtl/reservation_station_entry.sv - one station slot: state, operand capture and bus snooping
module rs_entry
    import reservation_station_pkg::*;
#(
    parameter logic [TAG_W-1:0] OWN_TAG = 3'd1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                load,
    input  logic [DATA_W-1:0]   load_instruction,
    input  logic [DATA_W-1:0]   load_vj,
    input  logic [DATA_W-1:0]   load_vk,
    input  logic [TAG_W-1:0]    load_qj,
    input  logic [TAG_W-1:0]    load_qk,
    input  logic                cdb_valid,
    input  logic [TAG_W-1:0]    cdb_tag,
    input  logic [DATA_W-1:0]   cdb_data,
    input  logic                dispatch,
    output entry_state_t        state,
    output logic [DATA_W-1:0]   instruction,
    output logic [DATA_W-1:0]   vj,
    output logic [DATA_W-1:0]   vk
);

    entry_state_t     next_state;
    logic [TAG_W-1:0] qj, qk;
    logic             in_hit_j, in_hit_k, hit_j, hit_k;
    logic [TAG_W-1:0] in_qj, in_qk, snoop_qj, snoop_qk;

    // Issue-time bypass: a producer finishing in the same cycle never leaves the operand pending.
    assign in_hit_j = tag_hit(cdb_valid, cdb_tag, load_qj);
    assign in_hit_k = tag_hit(cdb_valid, cdb_tag, load_qk);
    assign in_qj    = in_hit_j ? TAG_READY : load_qj;
    assign in_qk    = in_hit_k ? TAG_READY : load_qk;

    assign hit_j    = (state == ST_WAITING) && tag_hit(cdb_valid, cdb_tag, qj);
    assign hit_k    = (state == ST_WAITING) && tag_hit(cdb_valid, cdb_tag, qk);
    assign snoop_qj = hit_j ? TAG_READY : qj;
    assign snoop_qk = hit_k ? TAG_READY : qk;

    always_comb begin
        next_state = state;
        unique case (state)
            ST_EMPTY: begin
                if (load)
                    next_state = (in_qj == TAG_READY && in_qk == TAG_READY) ? ST_READY : ST_WAITING;
            end
            ST_WAITING: begin
                if (snoop_qj == TAG_READY && snoop_qk == TAG_READY)
                    next_state = ST_READY;
            end
            ST_READY: begin
                if (dispatch)
                    next_state = ST_EXECUTING;
            end
            ST_EXECUTING: begin
                if (cdb_valid && cdb_tag == OWN_TAG)
                    next_state = ST_EMPTY;
            end
            default: next_state = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= ST_EMPTY;
            instruction <= '0;
            vj          <= '0;
            vk          <= '0;
            qj          <= TAG_READY;
            qk          <= TAG_READY;
        end else begin
            state <= next_state;
            if (state == ST_EMPTY && load) begin
                instruction <= load_instruction;
                vj          <= in_hit_j ? cdb_data : load_vj;
                vk          <= in_hit_k ? cdb_data : load_vk;
                qj          <= in_qj;
                qk          <= in_qk;
            end else begin
                if (hit_j) begin
                    vj <= cdb_data;
                    qj <= TAG_READY;
                end
                if (hit_k) begin
                    vk <= cdb_data;
                    qk <= TAG_READY;
                end
            end
        end
    end

endmodule

// File: rtl/reservation_station.sv
// rtl/reservation_station.sv - reservation station top: allocation, dispatch select and FU output registers
module reservation_station
    import reservation_station_pkg::*;
#(
    parameter int               NUM_ENTRIES = 4,
    parameter logic [TAG_W-1:0] BASE_TAG    = 3'd1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                issue_valid,
    output logic                issue_ready,
    output logic [TAG_W-1:0]    issue_tag,
    input  logic [DATA_W-1:0]   issue_instruction,
    input  logic [DATA_W-1:0]   issue_vj,
    input  logic [DATA_W-1:0]   issue_vk,
    input  logic [TAG_W-1:0]    issue_qj,
    input  logic [TAG_W-1:0]    issue_qk,
    input  logic                cdb_valid,
    input  logic [TAG_W-1:0]    cdb_tag,
    input  logic [DATA_W-1:0]   cdb_data,
    input  logic                fu_stall,
    output logic                fu_instruct_in,
    output logic [DATA_W-1:0]   fu_instruction,
    output logic [DATA_W-1:0]   fu_reg1,
    output logic [DATA_W-1:0]   fu_reg2,
    output logic [TAG_W-1:0]    fu_code,
    output logic [2:0]          occupancy
);

    localparam int IDX_W = $clog2(NUM_ENTRIES);

    entry_state_t              state [NUM_ENTRIES];
    logic [DATA_W-1:0]         e_instruction [NUM_ENTRIES];
    logic [DATA_W-1:0]         e_vj [NUM_ENTRIES];
    logic [DATA_W-1:0]         e_vk [NUM_ENTRIES];
    logic [NUM_ENTRIES-1:0]    load, dispatch;
    logic                      have_empty, have_ready, do_issue, do_dispatch;
    logic [IDX_W-1:0]          empty_idx, ready_idx;
    logic [2:0]                count;

    // Scanning from the top down leaves the lowest matching index in the result.
    always_comb begin
        have_empty = 1'b0;
        have_ready = 1'b0;
        empty_idx  = '0;
        ready_idx  = '0;
        count      = '0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (state[i] == ST_EMPTY) begin
                have_empty = 1'b1;
                empty_idx  = IDX_W'(i);
            end
            if (state[i] == ST_READY) begin
                have_ready = 1'b1;
                ready_idx  = IDX_W'(i);
            end
            if (state[i] != ST_EMPTY)
                count = count + 3'd1;
        end
    end

    assign do_issue    = issue_valid && have_empty;
    assign do_dispatch = !fu_stall && have_ready;
    assign issue_ready = have_empty;
    assign issue_tag   = have_empty ? BASE_TAG + TAG_W'(empty_idx) : TAG_READY;
    assign occupancy   = count;

    always_comb begin
        load     = '0;
        dispatch = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            load[i]     = do_issue && (empty_idx == IDX_W'(i));
            dispatch[i] = do_dispatch && (ready_idx == IDX_W'(i));
        end
    end

    for (genvar i = 0; i < NUM_ENTRIES; i++) begin : g_entry
        rs_entry #(
            .OWN_TAG(TAG_W'(BASE_TAG + i))
        ) u_entry (
            .clock            (clock),
            .reset            (reset),
            .load             (load[i]),
            .load_instruction (issue_instruction),
            .load_vj          (issue_vj),
            .load_vk          (issue_vk),
            .load_qj          (issue_qj),
            .load_qk          (issue_qk),
            .cdb_valid        (cdb_valid),
            .cdb_tag          (cdb_tag),
            .cdb_data         (cdb_data),
            .dispatch         (dispatch[i]),
            .state            (state[i]),
            .instruction      (e_instruction[i]),
            .vj               (e_vj[i]),
            .vk               (e_vk[i])
        );
    end

    // FU payload holds its last value whenever nothing is dispatched.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fu_instruct_in <= 1'b0;
            fu_instruction <= '0;
            fu_reg1        <= '0;
            fu_reg2        <= '0;
            fu_code        <= TAG_READY;
        end else begin
            fu_instruct_in <= do_dispatch;
            if (do_dispatch) begin
                fu_instruction <= e_instruction[ready_idx];
                fu_reg1        <= e_vj[ready_idx];
                fu_reg2        <= e_vk[ready_idx];
                fu_code        <= BASE_TAG + TAG_W'(ready_idx);
            end
        end
    end

endmodule
